// File: rtl/alu_op_issuer.sv
// Command sequencer for the multicore ALU operand interface.
// Commands are queued in a small FIFO and issued one at a time. After the ALU
// result latency, the registered result and flag are returned on a
// valid/ready response channel.
module alu_op_issuer #(
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [7:0]                   cmd_a,
    input  logic [7:0]                   cmd_b,
    input  logic [3:0]                   cmd_op,
    output logic [7:0]                   alu_a,
    output logic [7:0]                   alu_b,
    output logic [3:0]                   alu_opcode,
    input  logic [15:0]                  alu_result,
    input  logic [15:0]                  alu_flag,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [15:0]                  rsp_result,
    output logic [1:0]                   rsp_flag,
    output logic [3:0]                   rsp_op,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [19:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [19:0]   head;
    logic [LW-1:0] cnt;
    logic          push;
    logic          pop;

    // Only the two low flag bits carry meaning; the rest are ignored.
    logic          unused_flag_bits;
    assign unused_flag_bits = ^alu_flag[15:2];

    // Ready comes from the registered count alone, so a pop in the same cycle
    // never opens a slot for a push while full.
    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);

    // Next-state logic; the FIFO head is popped only on the IDLE->WAIT transition.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage, packed as {op, a, b}; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // Operand issue, latency countdown and response capture/handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flag   <= '0;
            rsp_op     <= '0;
        end else begin
            if (pop) begin
                alu_opcode <= head[19:16];
                alu_a      <= head[15:8];
                alu_b      <= head[7:0];
                cnt        <= LW'(LAT);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - LW'(1);
            end

            if (state == WAIT && cnt == '0) begin
                rsp_result <= alu_result;
                rsp_flag   <= alu_flag[1:0];
                rsp_op     <= alu_opcode;
                rsp_valid  <= 1'b1;
            end else if (state == RESP && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: a LAT=1 instance driven by a vector
// table plus directed sequences, and a LAT=2 instance for the latency check.
module tb_alu_op_issuer;

    logic        clk;
    logic        rst;

    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_op;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_result, alu_flag;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_flag;
    logic [3:0]  rsp_op;
    logic        busy;
    logic [2:0]  count;

    logic        cmd2_valid, cmd2_ready;
    logic [7:0]  cmd2_a, cmd2_b;
    logic [3:0]  cmd2_op;
    logic [7:0]  alu2_a, alu2_b;
    logic [3:0]  alu2_opcode;
    logic [15:0] alu2_result, alu2_flag;
    logic        rsp2_valid, rsp2_ready;
    logic [15:0] rsp2_result;
    logic [1:0]  rsp2_flag;
    logic [3:0]  rsp2_op;
    logic        busy2;
    logic [2:0]  count2;

    int compared;
    int mismatched;

    alu_op_issuer #(.DEPTH(4), .LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_op(rsp_op),
        .busy(busy), .count(count)
    );

    alu_op_issuer #(.DEPTH(4), .LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd2_valid), .cmd_ready(cmd2_ready),
        .cmd_a(cmd2_a), .cmd_b(cmd2_b), .cmd_op(cmd2_op),
        .alu_a(alu2_a), .alu_b(alu2_b), .alu_opcode(alu2_opcode),
        .alu_result(alu2_result), .alu_flag(alu2_flag),
        .rsp_valid(rsp2_valid), .rsp_ready(rsp2_ready),
        .rsp_result(rsp2_result), .rsp_flag(rsp2_flag), .rsp_op(rsp2_op),
        .busy(busy2), .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: op[1:0] 00 add, 01 sub, 10 mul, 11 zero.
    // Returns {borrow/carry, nonzero, result}.
    function automatic logic [17:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        logic [15:0] r;
        logic        c;
        r = 16'h0;
        c = 1'b0;
        case (op[1:0])
            2'b00: begin r = 16'(a) + 16'(b); c = r[8]; end
            2'b01: begin r = 16'(a) - 16'(b); c = (a < b); end
            2'b10: r = 16'(a) * 16'(b);
            default: r = 16'h0;
        endcase
        return {c, (r != 16'h0), r};
    endfunction

    // ALU model for the LAT=1 instance: one register stage; junk in upper flag bits.
    logic [17:0] alu1_q;
    always_ff @(posedge clk) alu1_q <= alu_fn(alu_a, alu_b, alu_opcode);
    assign alu_result = alu1_q[15:0];
    assign alu_flag   = {14'h2AAA, alu1_q[17:16]};

    // ALU model for the LAT=2 instance: two register stages.
    logic [17:0] alu2_s1, alu2_q;
    always_ff @(posedge clk) begin
        alu2_s1 <= alu_fn(alu2_a, alu2_b, alu2_opcode);
        alu2_q  <= alu2_s1;
    end
    assign alu2_result = alu2_q[15:0];
    assign alu2_flag   = {14'h1555, alu2_q[17:16]};

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic [15:0] res;
        logic [1:0]  flag;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out, got no handshake, expected one", name);
    endtask

    // Push one command; entered and left at a negedge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int guard;
        guard     = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) timeoutFail("cmd_accept");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitRspValid(input string name);
        int guard;
        guard = 0;
        while (!rsp_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) timeoutFail(name);
    endtask

    // Wait for a response, compare it, then let rsp_ready consume it.
    task automatic checkOutput(input string name, input logic [15:0] res,
                               input logic [1:0] flag, input logic [3:0] op);
        waitRspValid({name, "_valid"});
        check({name, "_result"}, 32'(rsp_result), 32'(res));
        check({name, "_flag"},   32'(rsp_flag),   32'(flag));
        check({name, "_op"},     32'(rsp_op),     32'(op));
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          accepted;
        logic        stale;
        logic [15:0] alu2_seen;
        logic [17:0] e;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_op     = '0;
        rsp_ready  = 1'b1;
        cmd2_valid = 1'b0;
        cmd2_a     = '0;
        cmd2_b     = '0;
        cmd2_op    = '0;
        rsp2_ready = 1'b1;

        vecs[0] = '{8'h12, 8'h34, 4'h0, 16'h0046, 2'b01};
        vecs[1] = '{8'hFF, 8'hFF, 4'h6, 16'hFE01, 2'b01};
        vecs[2] = '{8'h05, 8'h05, 4'h9, 16'h0000, 2'b00};
        vecs[3] = '{8'hF0, 8'h20, 4'h4, 16'h0110, 2'b11};
        vecs[4] = '{8'h03, 8'h07, 4'hD, 16'hFFFC, 2'b11};
        vecs[5] = '{8'hAB, 8'hCD, 4'hF, 16'h0000, 2'b00};
        vecs[6] = '{8'h10, 8'h10, 4'hA, 16'h0100, 2'b01};
        vecs[7] = '{8'h00, 8'h00, 4'h0, 16'h0000, 2'b00};

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_alu_opc",   32'(alu_opcode),32'd0);
        check("rst_rsp_res",   32'(rsp_result),32'd0);

        $display("[TB] single add, cycle-exact");
        cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 4'h0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("e0_count", 32'(count), 32'd1);
        check("e0_busy",  32'(busy),  32'd1);
        @(negedge clk);
        check("e1_alu_a",   32'(alu_a),      32'h12);
        check("e1_alu_b",   32'(alu_b),      32'h34);
        check("e1_alu_opc", 32'(alu_opcode), 32'h0);
        check("e1_count",   32'(count),      32'd0);
        @(negedge clk);
        check("e2_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("e3_rsp_valid", 32'(rsp_valid),  32'd1);
        check("e3_rsp_res",   32'(rsp_result), 32'h0046);
        check("e3_rsp_flag",  32'(rsp_flag),   32'h1);
        check("e3_rsp_op",    32'(rsp_op),     32'h0);
        @(negedge clk);
        check("e4_rsp_valid", 32'(rsp_valid), 32'd0);
        check("e4_alu_a_held",32'(alu_a),     32'h12);

        $display("[TB] ordering mul then sub");
        applyStimulus(8'hFF, 8'hFF, 4'h6);
        applyStimulus(8'h05, 8'h05, 4'h9);
        checkOutput("ord0", 16'hFE01, 2'b01, 4'h6);
        checkOutput("ord1", 16'h0000, 2'b00, 4'h9);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
            checkOutput($sformatf("vec%0d", i), vecs[i].res, vecs[i].flag, vecs[i].op);
        end

        $display("[TB] backpressure and full");
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_a = 8'h10 + 8'(i); cmd_b = 8'h01; cmd_op = 4'h0; cmd_valid = 1'b1;
            if (cmd_ready) accepted++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("bp_accepted",  32'(accepted),   32'd5);
        check("bp_count",     32'(count),      32'd4);
        check("bp_cmd_ready", 32'(cmd_ready),  32'd0);
        check("bp_rsp_valid", 32'(rsp_valid),  32'd1);
        repeat (3) @(negedge clk);
        check("bp_res_held",  32'(rsp_result), 32'h0011);
        check("bp_valid_held",32'(rsp_valid),  32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d", i), 16'h0011 + 16'(i), 2'b01, 4'h0);
        end
        check("bp_count_end", 32'(count), 32'd0);
        check("bp_busy_end",  32'(busy),  32'd0);

        $display("[TB] simultaneous push and pop");
        rsp_ready = 1'b0;
        applyStimulus(8'h01, 8'h02, 4'h0);
        applyStimulus(8'h03, 8'h04, 4'h0);
        applyStimulus(8'h05, 8'h06, 4'h0);
        waitRspValid("sp_first_valid");
        check("sp_count2",  32'(count),      32'd2);
        check("sp_first",   32'(rsp_result), 32'h0003);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("sp_idle_count", 32'(count),     32'd2);
        check("sp_idle_valid", 32'(rsp_valid), 32'd0);
        applyStimulus(8'h07, 8'h08, 4'h0);
        check("sp_count_same", 32'(count), 32'd2);
        checkOutput("sp1", 16'h0007, 2'b01, 4'h0);
        checkOutput("sp2", 16'h000B, 2'b01, 4'h0);
        checkOutput("sp3", 16'h000F, 2'b01, 4'h0);

        $display("[TB] pointer wrap, 2*DEPTH+1 ops");
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    applyStimulus(8'(i * 37 + 5), 8'(i * 11 + 3), 4'(i * 5));
                end
            end
            begin
                for (int j = 0; j < 9; j++) begin
                    e = alu_fn(8'(j * 37 + 5), 8'(j * 11 + 3), 4'(j * 5));
                    checkOutput($sformatf("wrap%0d", j), e[15:0], e[17:16], 4'(j * 5));
                end
            end
        join
        check("wrap_count_end", 32'(count), 32'd0);

        $display("[TB] reset mid-operation");
        rsp_ready = 1'b0;
        applyStimulus(8'h40, 8'h02, 4'h2);
        waitRspValid("rm_first_valid");
        check("rm_first_res", 32'(rsp_result), 32'h0080);
        applyStimulus(8'h21, 8'h01, 4'h0);
        applyStimulus(8'h22, 8'h01, 4'h0);
        applyStimulus(8'h23, 8'h01, 4'h0);
        check("rm_count3", 32'(count), 32'd3);
        rsp_ready = 1'b1;
        cmd_a = 8'h24; cmd_b = 8'h01; cmd_op = 4'h0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rm_count4", 32'(count), 32'd4);
        @(negedge clk);
        check("rm_wait_count", 32'(count),     32'd3);
        check("rm_wait_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rm_count",     32'(count),     32'd0);
        check("rm_busy",      32'(busy),      32'd0);
        check("rm_alu_a",     32'(alu_a),     32'd0);
        check("rm_alu_b",     32'(alu_b),     32'd0);
        check("rm_alu_opc",   32'(alu_opcode),32'd0);
        rst   = 1'b0;
        stale = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) stale = 1'b1;
        end
        check("rm_no_stale",  32'(stale),     32'd0);
        check("rm_count_end", 32'(count),     32'd0);
        check("rm_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("[TB] LAT=2 instance");
        cmd2_a = 8'h21; cmd2_b = 8'h03; cmd2_op = 4'h2; cmd2_valid = 1'b1;
        @(negedge clk);
        cmd2_valid = 1'b0;
        @(negedge clk);
        check("l2_e1_alu_a", 32'(alu2_a), 32'h21);
        @(negedge clk);
        check("l2_e2_valid", 32'(rsp2_valid), 32'd0);
        @(negedge clk);
        check("l2_e3_valid", 32'(rsp2_valid), 32'd0);
        alu2_seen = alu2_result;
        check("l2_e3_alu_out", 32'(alu2_seen), 32'h0063);
        @(negedge clk);
        check("l2_e4_valid", 32'(rsp2_valid),  32'd1);
        check("l2_e4_res",   32'(rsp2_result), 32'h0063);
        check("l2_e4_flag",  32'(rsp2_flag),   32'h1);
        check("l2_e4_op",    32'(rsp2_op),     32'h2);
        @(negedge clk);
        check("l2_e5_valid", 32'(rsp2_valid), 32'd0);
        check("l2_e5_busy",  32'(busy2),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Front-end command sequencer that drives the A/B/opcode operand interface of the multicore ALU and collects its registered result and flag.
- Accepts operations over a valid/ready command channel and buffers them in a small FIFO.
- Issues one operation at a time, waits the ALU result latency, then returns result and flag over a valid/ready response channel.
- Sits between a host/controller and the multicore ALU; it is the producer of operands and the consumer of results for that interface.

Parameters:
- DEPTH, 4: command FIFO entries; power of 2, at least 2.
- LAT, 1: clock edges from the ALU operand change to a valid ALU result; at least 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command FIFO can accept.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  4  opcode; [3:2] selects the core, [1:0] selects the operation.
- alu_a  out  8  registered operand A to the ALU.
- alu_b  out  8  registered operand B to the ALU.
- alu_opcode  out  4  registered opcode to the ALU.
- alu_result  in  16  ALU result.
- alu_flag  in  16  ALU flag; only [1:0] meaningful.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_result  out  16  captured result.
- rsp_flag  out  2  captured alu_flag[1:0].
- rsp_op  out  4  opcode of the operation that produced the response.
- busy  out  1  high when state != IDLE or FIFO is non-empty.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - FIFO is flushed; count=0; state goes to IDLE.
  - alu_a, alu_b, alu_opcode, rsp_result, rsp_flag, rsp_op and rsp_valid all go to 0.
  - cmd_ready=1 once rst is deasserted.
  - Reset mid-operation discards the in-flight op and all queued ops; no response is produced for them.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = (count != DEPTH), derived from registered count.
  - A pop in the same cycle does not free a slot for a push while full.
  - Simultaneous push and pop with count not full leaves count unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Strict FIFO order is preserved end to end.
- FSM, states IDLE, WAIT, RESP:
  - IDLE: if count != 0, pop the head at this edge, load alu_a, alu_b and alu_opcode from it, set cnt=LAT, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: alu_* are held stable and cnt decrements each edge. At the edge where cnt==0, capture rsp_result<=alu_result, rsp_flag<=alu_flag[1:0], rsp_op<=alu_opcode and rsp_valid<=1, then go to RESP.
  - RESP: rsp_* are held stable while rsp_ready=0. On rsp_valid && rsp_ready, rsp_valid<=0 at that edge and the next state is IDLE. This adds one bubble cycle per op.
  - Commands may be pushed in any state.
- Latency: with the block idle and an empty FIFO, a push at edge 0 gives a pop at edge 1, capture at edge LAT+2, and rsp_valid high after edge LAT+2 (edge 3 for LAT=1).
  - Throughput is one op per LAT+3 cycles when rsp_ready is held at 1.
- Data handling:
  - alu_* hold their last issued values between ops; they are never re-zeroed except by reset.
  - No arithmetic is performed in this block; the result is passed through at 16 bits unchanged.
  - opcode[1:0]=2'b11 is issued normally, and the ALU's 0 result is returned.
- Capacity: with rsp_ready held at 0, one op sits in RESP, so up to DEPTH further commands are accepted (DEPTH+1 total) before cmd_ready=0.

Test Plan:
- Reset and single add:
  - Stimulus: rst for 2 cycles; then push A=0x12, B=0x34, op=4'b0000 at edge 0, with rsp_ready=1.
  - Response: alu_a/alu_b/alu_opcode=0x12/0x34/0x0 after edge 1; rsp_valid=1 after edge 3 with rsp_result=0x0046, rsp_flag=2'b01, rsp_op=0x0; rsp_valid=0 after edge 4.
- Ordering, multiply and subtract:
  - Stimulus: back-to-back push of 0xFF*0xFF (op 4'b0110), then 0x05-0x05 (op 4'b1001).
  - Response: responses arrive in order: 0xFE01 with flag 01 and rsp_op 0x6, then 0x0000 with flag 00 and rsp_op 0x9.
- Backpressure and full:
  - Stimulus: rsp_ready=0; push 6 distinct ops continuously.
  - Response: cmd_ready drops after the 5th accept; count=4; rsp_result stays constant while stalled.
  - Then assert rsp_ready=1: all 5 responses drain in order and count returns to 0 with busy=0.
- Simultaneous push and pop:
  - Stimulus: count=2; push in the same cycle IDLE pops.
  - Response: count stays 2; no data lost or duplicated across pointer wrap, checked by pushing 2*DEPTH+1 ops.
- Reset mid-operation:
  - Stimulus: rst asserted in WAIT with 3 queued ops.
  - Response: next cycle rsp_valid=0, count=0, busy=0, alu_*=0; no stale response appears after rst is released.
- LAT=2 build:
  - Stimulus: single op pushed at edge 0.
  - Response: rsp_valid=1 after edge 4, and the captured value matches the ALU output registered at edge 3.
